// File: rtl/pnode_tagger_if.sv
// Stream bundle of pnode_tagger: raw Avalon-ST receive beats in, tagged
// 142-bit pnode beats and the per-packet tag side-stream out.
interface pnode_tagger_if;
   logic [127:0] avalon_st_rx_data;
   logic         avalon_st_rx_sop;
   logic         avalon_st_rx_eop;
   logic         avalon_st_rx_valid;
   logic         avalon_st_rx_ready;
   logic [141:0] pnode_data;
   logic         pnode_valid;
   logic         pnode_ready;
   logic [11:0]  tag_out;
   logic         tag_valid;

   // master is the surrounding environment, slave is the tagger itself
   modport master (
      output avalon_st_rx_data, avalon_st_rx_sop, avalon_st_rx_eop, avalon_st_rx_valid,
      input  avalon_st_rx_ready,
      input  pnode_data, pnode_valid,
      output pnode_ready,
      input  tag_out, tag_valid
   );

   modport slave (
      input  avalon_st_rx_data, avalon_st_rx_sop, avalon_st_rx_eop, avalon_st_rx_valid,
      output avalon_st_rx_ready,
      output pnode_data, pnode_valid,
      input  pnode_ready,
      output tag_out, tag_valid
   );
endinterface

// File: rtl/pnode_tagger.sv
// Packet tagger: frames the raw Avalon-ST stream, stamps each packet with a wrapping
// tag and emits pnode beats through a 2-entry skid buffer. PNODE_MAXLEN_EN adds length policing.
module pnode_tagger #(
   parameter int TAG_W     = 12,
   parameter int MAXBEATS  = 96,
   parameter int DROPCNT_W = 16
) (
   input  logic          clock,
   input  logic          reset,
   pnode_tagger_if.slave bus,
   input  logic [1:0]    avs_csr_address,
   input  logic          avs_csr_read,
   output logic [31:0]   avs_csr_readdata,
   input  logic          avs_csr_write,
   input  logic [31:0]   avs_csr_writedata
);
   localparam int BEAT_W = TAG_W + 130;

   typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, DISCARD = 2'd2} state_t;

   state_t                 state_reg, state_next;
   logic [TAG_W-1:0]       tag_reg, tag_next;
   logic                   tag_pend_reg, tag_pend_next;
   logic [TAG_W-1:0]       tag_load_reg, tag_load_next;
   logic [BEAT_W-1:0]      head_reg, head_next;
   logic [BEAT_W-1:0]      tail_reg, tail_next;
   logic [1:0]             count_reg, count_next;
   logic                   ready_reg, ready_next;
   logic                   enable_reg, enable_next;
   logic                   tag_valid_reg, tag_valid_next;
   logic [TAG_W-1:0]       tag_out_reg, tag_out_next;
   logic [31:0]            pkt_count_reg, pkt_count_next;
   logic [DROPCNT_W-1:0]   drop_count_reg, drop_count_next;
   logic [31:0]            readdata_reg, readdata_next;

   logic                   accept, pop, push, push_sop, push_eop, fresh_sop, drop_inc;
   logic                   eop_pop;
   logic [TAG_W-1:0]       push_tag;
   logic [BEAT_W-1:0]      push_beat;
   logic                   csr_wr_pkt, csr_wr_drop, csr_wr_tag, csr_wr_en;

`ifdef PNODE_MAXLEN_EN
   localparam int BC_W = $clog2(MAXBEATS + 1);
   logic [BC_W-1:0]        beatcnt_reg, beatcnt_next;
   logic                   unused_bits;
   assign unused_bits = ^avs_csr_writedata[31:TAG_W];
`else
   logic                   unused_bits;
   assign unused_bits = (^avs_csr_writedata[31:TAG_W]) ^ (MAXBEATS > 0);
`endif

   assign csr_wr_pkt  = avs_csr_write && (avs_csr_address == 2'd0);
   assign csr_wr_drop = avs_csr_write && (avs_csr_address == 2'd1);
   assign csr_wr_tag  = avs_csr_write && (avs_csr_address == 2'd2);
   assign csr_wr_en   = avs_csr_write && (avs_csr_address == 2'd3);

   always_comb begin
      accept     = bus.avalon_st_rx_valid && ready_reg;
      pop        = (count_reg != 2'd0) && bus.pnode_ready;
      eop_pop    = pop && head_reg[128];
      state_next = state_reg;
      tag_next   = tag_reg;
      push       = 1'b0;
      push_sop   = 1'b0;
      push_eop   = 1'b0;
      push_tag   = tag_reg;
      fresh_sop  = 1'b0;
      drop_inc   = 1'b0;
`ifdef PNODE_MAXLEN_EN
      beatcnt_next = beatcnt_reg;
`endif
      if (accept) begin
         case (state_reg)
            IDLE: begin
               if (bus.avalon_st_rx_sop) fresh_sop = 1'b1;
               else                      drop_inc  = 1'b1;
            end
            PKT: begin
               if (bus.avalon_st_rx_sop) begin
                  // abandoned packet: retire its tag, then restart on this sop
                  tag_next  = tag_reg + TAG_W'(1);
                  drop_inc  = 1'b1;
                  fresh_sop = 1'b1;
               end else begin
                  push     = 1'b1;
                  push_eop = bus.avalon_st_rx_eop;
`ifdef PNODE_MAXLEN_EN
                  beatcnt_next = beatcnt_reg + BC_W'(1);
`endif
                  if (bus.avalon_st_rx_eop) begin
                     tag_next   = tag_reg + TAG_W'(1);
                     state_next = IDLE;
                  end
`ifdef PNODE_MAXLEN_EN
                  else if (beatcnt_reg == BC_W'(MAXBEATS - 1)) begin
                     push_eop   = 1'b1;
                     tag_next   = tag_reg + TAG_W'(1);
                     drop_inc   = 1'b1;
                     state_next = DISCARD;
                  end
`endif
               end
            end
            default: begin
               if (bus.avalon_st_rx_sop)      fresh_sop  = 1'b1;
               else if (bus.avalon_st_rx_eop) state_next = IDLE;
            end
         endcase
         if (fresh_sop) begin
            push     = 1'b1;
            push_sop = 1'b1;
            push_eop = bus.avalon_st_rx_eop;
            push_tag = tag_next;
            if (bus.avalon_st_rx_eop) begin
               tag_next   = tag_next + TAG_W'(1);
               state_next = IDLE;
            end else begin
               state_next = PKT;
`ifdef PNODE_MAXLEN_EN
               beatcnt_next = BC_W'(1);
`endif
            end
         end
      end

      // a tag load waits until the packet in flight has closed
      tag_pend_next = tag_pend_reg || csr_wr_tag;
      tag_load_next = csr_wr_tag ? avs_csr_writedata[TAG_W-1:0] : tag_load_reg;
      if (tag_pend_next && (state_next == IDLE)) begin
         tag_next      = tag_load_next;
         tag_pend_next = 1'b0;
      end

      push_beat  = {push_tag, push_sop, push_eop, bus.avalon_st_rx_data};
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      case ({push, pop})
         2'b10: begin
            if (count_reg == 2'd0) head_next = push_beat;
            else                   tail_next = push_beat;
            count_next = count_reg + 2'd1;
         end
         2'b01: begin
            head_next  = tail_reg;
            count_next = count_reg - 2'd1;
         end
         2'b11: begin
            if (count_reg == 2'd1) begin
               head_next = push_beat;
            end else begin
               head_next = tail_reg;
               tail_next = push_beat;
            end
         end
         default: ;
      endcase

      enable_next = csr_wr_en ? avs_csr_writedata[0] : enable_reg;
      ready_next  = (count_next < 2'd2) && (enable_next || (state_next != IDLE));

      tag_valid_next  = eop_pop;
      tag_out_next    = eop_pop ? head_reg[BEAT_W-1 -: TAG_W] : tag_out_reg;
      pkt_count_next  = csr_wr_pkt ? 32'd0 : (eop_pop ? pkt_count_reg + 32'd1 : pkt_count_reg);
      drop_count_next = drop_count_reg;
      if (csr_wr_drop)                        drop_count_next = '0;
      else if (drop_inc && !(&drop_count_reg)) drop_count_next = drop_count_reg + DROPCNT_W'(1);

      readdata_next = readdata_reg;
      if (avs_csr_read) begin
         case (avs_csr_address)
            2'd0:    readdata_next = pkt_count_reg;
            2'd1:    readdata_next = 32'(drop_count_reg);
            2'd2:    readdata_next = 32'(tag_reg);
            default: readdata_next = {31'd0, enable_reg};
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         tag_reg        <= '0;
         tag_pend_reg   <= 1'b0;
         tag_load_reg   <= '0;
         head_reg       <= '0;
         tail_reg       <= '0;
         count_reg      <= 2'd0;
         ready_reg      <= 1'b0;
         enable_reg     <= 1'b1;
         tag_valid_reg  <= 1'b0;
         tag_out_reg    <= '0;
         pkt_count_reg  <= 32'd0;
         drop_count_reg <= '0;
         readdata_reg   <= 32'd0;
`ifdef PNODE_MAXLEN_EN
         beatcnt_reg    <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         tag_reg        <= tag_next;
         tag_pend_reg   <= tag_pend_next;
         tag_load_reg   <= tag_load_next;
         head_reg       <= head_next;
         tail_reg       <= tail_next;
         count_reg      <= count_next;
         ready_reg      <= ready_next;
         enable_reg     <= enable_next;
         tag_valid_reg  <= tag_valid_next;
         tag_out_reg    <= tag_out_next;
         pkt_count_reg  <= pkt_count_next;
         drop_count_reg <= drop_count_next;
         readdata_reg   <= readdata_next;
`ifdef PNODE_MAXLEN_EN
         beatcnt_reg    <= beatcnt_next;
`endif
      end
   end

   assign bus.avalon_st_rx_ready = ready_reg;
   assign bus.pnode_data         = head_reg;
   assign bus.pnode_valid        = (count_reg != 2'd0);
   assign bus.tag_out            = tag_out_reg;
   assign bus.tag_valid          = tag_valid_reg;
   assign avs_csr_readdata       = readdata_reg;
endmodule

// File: tb/tb_pnode_tagger.sv
// Directed bench for pnode_tagger: framing/tag table plus hand sequences for
// wrap, backpressure, enable gating and (with PNODE_MAXLEN_EN) truncation.
module tb_pnode_tagger;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avs_csr_address = 2'd0;
   logic        avs_csr_read = 1'b0;
   logic [31:0] avs_csr_readdata;
   logic        avs_csr_write = 1'b0;
   logic [31:0] avs_csr_writedata = 32'd0;

   always #5 clock = ~clock;

   pnode_tagger_if bus();

   pnode_tagger #(.TAG_W(12), .MAXBEATS(4), .DROPCNT_W(16)) dut (
      .clock             (clock),
      .reset             (reset),
      .bus               (bus),
      .avs_csr_address   (avs_csr_address),
      .avs_csr_read      (avs_csr_read),
      .avs_csr_readdata  (avs_csr_readdata),
      .avs_csr_write     (avs_csr_write),
      .avs_csr_writedata (avs_csr_writedata)
   );

   typedef struct {
      logic       sop;
      logic       eop;
      logic       out;
      logic [11:0] tag;
   } vec_t;

   vec_t         vecs[18];
   int           checks = 0;
   int           errors = 0;
   logic [141:0] out_q[$];
   logic [141:0] exp_q[$];
   logic [11:0]  tag_q[$];
   logic [11:0]  exp_tag_q[$];

   always @(posedge clock)
      if (bus.pnode_valid && bus.pnode_ready) out_q.push_back(bus.pnode_data);

   always @(negedge clock)
      if (bus.tag_valid) tag_q.push_back(bus.tag_out);

   function automatic logic [127:0] dat(input int i);
      return {4{32'hA5A50000 | 32'(i)}};
   endfunction

   function automatic logic [141:0] img(input logic [11:0] t, input logic s, input logic e,
                                        input logic [127:0] d);
      return {t, s, e, d};
   endfunction

   task automatic chk(input string nm, input logic [141:0] act, input logic [141:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
      avs_csr_address   = a;
      avs_csr_writedata = d;
      avs_csr_write     = 1'b1;
      @(posedge clock); #1;
      avs_csr_write     = 1'b0;
   endtask

   task automatic csr_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
      avs_csr_address = a;
      avs_csr_read    = 1'b1;
      @(posedge clock); #1;
      avs_csr_read    = 1'b0;
      chk(nm, 142'(avs_csr_readdata), 142'(exp));
   endtask

   task automatic drive(input logic s, input logic e, input logic [127:0] d);
      bus.avalon_st_rx_sop   = s;
      bus.avalon_st_rx_eop   = e;
      bus.avalon_st_rx_data  = d;
      bus.avalon_st_rx_valid = 1'b1;
   endtask

   task automatic send(input logic s, input logic e, input logic [127:0] d);
      int wait_n = 0;
      drive(s, e, d);
      while (!bus.avalon_st_rx_ready && wait_n < 200) begin
         @(posedge clock); #1;
         wait_n++;
      end
      if (wait_n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: ready stayed 0 for %0d cycles, required 1", wait_n);
      end else begin
         @(posedge clock); #1;
      end
      bus.avalon_st_rx_valid = 1'b0;
   endtask

   task automatic drain;
      repeat (6) @(posedge clock);
      #1;
   endtask

   task automatic compare_outputs(input string nm);
      chk({nm, "_beats"}, 142'(out_q.size()), 142'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         chk($sformatf("%s_beat%0d", nm, i), out_q[i], exp_q[i]);
      chk({nm, "_tags"}, 142'(tag_q.size()), 142'(exp_tag_q.size()));
      for (int i = 0; i < exp_tag_q.size() && i < tag_q.size(); i++)
         chk($sformatf("%s_tag%0d", nm, i), 142'(tag_q[i]), 142'(exp_tag_q[i]));
      out_q.delete();
      exp_q.delete();
      tag_q.delete();
      exp_tag_q.delete();
   endtask

   initial begin
      int acc_n;
      logic [11:0] t;

      // three 4-beat packets, a stray beat, then a packet abandoned by a new sop
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < 4; b++)
            vecs[p*4+b] = '{sop: (b == 0), eop: (b == 3), out: 1'b1, tag: 12'(p)};
      vecs[12] = '{sop: 1'b0, eop: 1'b0, out: 1'b0, tag: 12'd0};
      vecs[13] = '{sop: 1'b1, eop: 1'b0, out: 1'b1, tag: 12'd3};
      vecs[14] = '{sop: 1'b0, eop: 1'b0, out: 1'b1, tag: 12'd3};
      vecs[15] = '{sop: 1'b1, eop: 1'b0, out: 1'b1, tag: 12'd4};
      vecs[16] = '{sop: 1'b0, eop: 1'b0, out: 1'b1, tag: 12'd4};
      vecs[17] = '{sop: 1'b0, eop: 1'b1, out: 1'b1, tag: 12'd4};

      bus.avalon_st_rx_data  = '0;
      bus.avalon_st_rx_sop   = 1'b0;
      bus.avalon_st_rx_eop   = 1'b0;
      bus.avalon_st_rx_valid = 1'b0;
      bus.pnode_ready        = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", 142'(bus.avalon_st_rx_ready), 142'd0);
      chk("rst_pvalid", 142'(bus.pnode_valid), 142'd0);
      chk("rst_pdata", bus.pnode_data, 142'd0);
      chk("rst_tag_valid", 142'(bus.tag_valid), 142'd0);
      chk("rst_readdata", 142'(avs_csr_readdata), 142'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_ready_up", 142'(bus.avalon_st_rx_ready), 142'd1);
      csr_check("rst_csr0", 2'd0, 32'd0);
      csr_check("rst_csr2", 2'd2, 32'd0);
      csr_check("rst_csr3", 2'd3, 32'd1);

      for (int i = 0; i < 18; i++) begin
         send(vecs[i].sop, vecs[i].eop, dat(i));
         if (vecs[i].out) exp_q.push_back(img(vecs[i].tag, vecs[i].sop, vecs[i].eop, dat(i)));
         if (vecs[i].out && vecs[i].eop) exp_tag_q.push_back(vecs[i].tag);
         if (i == 11) begin
            drain;
            compare_outputs("pkt3");
            csr_check("csr0_after3", 2'd0, 32'd3);
            csr_check("csr1_clean", 2'd1, 32'd0);
         end
      end
      drain;
      compare_outputs("stray_abandon");
      csr_check("csr1_drops", 2'd1, 32'd2);
      csr_check("csr2_next", 2'd2, 32'd5);
      csr_check("csr0_pkts", 2'd0, 32'd4);

      // tag wrap through 4095
      csr_write(2'd2, 32'd4094);
      for (int k = 0; k < 5; k++) begin
         t = 12'(4094 + k);
         send(1'b1, 1'b1, dat(100 + k));
         exp_q.push_back(img(t, 1'b1, 1'b1, dat(100 + k)));
         exp_tag_q.push_back(t);
      end
      drain;
      compare_outputs("wrap");
      csr_check("wrap_next", 2'd2, 32'd3);

      // downstream stall for 10 cycles during a 6-beat packet
      bus.pnode_ready = 1'b0;
      acc_n = 0;
      drive(1'b1, 1'b0, dat(200));
      for (int c = 0; c < 10; c++) begin
         if (bus.avalon_st_rx_ready) acc_n++;
         @(posedge clock); #1;
         drive(acc_n == 0, 1'b0, dat(200 + acc_n));
         if (c >= 1) chk($sformatf("bp_ready_c%0d", c), 142'(bus.avalon_st_rx_ready), 142'd0);
         chk($sformatf("bp_hold_c%0d", c), bus.pnode_data, img(12'd3, 1'b1, 1'b0, dat(200)));
      end
      chk("bp_accepted", 142'(acc_n), 142'd2);
      bus.pnode_ready = 1'b1;
      for (int j = 2; j < 6; j++) send(1'b0, j == 5, dat(200 + j));
      for (int j = 0; j < 6; j++) exp_q.push_back(img(12'd3, j == 0, j == 5, dat(200 + j)));
      exp_tag_q.push_back(12'd3);
      drain;
      compare_outputs("backpressure");

      // disable mid-packet: packet completes, then input is gated
      send(1'b1, 1'b0, dat(300));
      send(1'b0, 1'b0, dat(301));
      csr_write(2'd3, 32'd0);
      chk("en_ready_pkt", 142'(bus.avalon_st_rx_ready), 142'd1);
      send(1'b0, 1'b0, dat(302));
      send(1'b0, 1'b1, dat(303));
      chk("en_ready_off", 142'(bus.avalon_st_rx_ready), 142'd0);
      drive(1'b1, 1'b1, dat(310));
      repeat (4) @(posedge clock);
      #1;
      chk("en_ready_held", 142'(bus.avalon_st_rx_ready), 142'd0);
      csr_write(2'd3, 32'd1);
      send(1'b1, 1'b1, dat(310));
      for (int j = 0; j < 4; j++) exp_q.push_back(img(12'd4, j == 0, j == 3, dat(300 + j)));
      exp_q.push_back(img(12'd5, 1'b1, 1'b1, dat(310)));
      exp_tag_q.push_back(12'd4);
      exp_tag_q.push_back(12'd5);
      drain;
      compare_outputs("enable");
      csr_check("en_csr3", 2'd3, 32'd1);

`ifdef PNODE_MAXLEN_EN
      // 7-beat packet truncated to 4 beats
      csr_write(2'd1, 32'd0);
      for (int j = 0; j < 7; j++) send(j == 0, j == 6, dat(400 + j));
      send(1'b1, 1'b1, dat(410));
      for (int j = 0; j < 4; j++) exp_q.push_back(img(12'd6, j == 0, j == 3, dat(400 + j)));
      exp_q.push_back(img(12'd7, 1'b1, 1'b1, dat(410)));
      exp_tag_q.push_back(12'd6);
      exp_tag_q.push_back(12'd7);
      drain;
      compare_outputs("maxlen");
      csr_check("maxlen_drops", 2'd1, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule

// File: doc/pnode_tagger.md
Name: pnode_tagger

Overview:
- Upstream neighbour of the vector match stage.
- Accepts the raw 128-bit Avalon-ST receive stream and assigns each packet a 12-bit tag from a wrapping counter.
- Emits the 142-bit pnode beat {tag[11:0], sop, eop, data[127:0]} with a valid/ready handshake, plus a per-packet tag side-stream for the packet buffer.
- Enforces framing, with optional length policing, and keeps CSR-visible statistics.

Parameters:
- TAG_W, 12, tag width; fixed by the pnode format.
- MAXBEATS, 96, maximum 128-bit beats per packet (1536 B); used only with PNODE_MAXLEN_EN.
- DROPCNT_W, 16, width of the saturating drop counter.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- avalon_st_rx_data  in  128  packet data.
- avalon_st_rx_sop  in  1  start of packet.
- avalon_st_rx_eop  in  1  end of packet.
- avalon_st_rx_valid  in  1  beat valid.
- avalon_st_rx_ready  out  1  beat accepted when valid&&ready.
- pnode_data  out  142  [141:130] tag, [129] sop, [128] eop, [127:0] data.
- pnode_valid  out  1  output beat valid.
- pnode_ready  in  1  downstream may accept.
- tag_out  out  12  tag of the packet just completed.
- tag_valid  out  1  one-cycle pulse when a tagged eop leaves on pnode.
- avs_csr_address  in  2  CSR select.
- avs_csr_read  in  1  CSR read strobe.
- avs_csr_readdata  out  32  registered read data, valid 1 cycle after read.
- avs_csr_write  in  1  CSR write strobe.
- avs_csr_writedata  in  32  CSR write data.

Behaviour:
- Reset state (reset=0, asynchronous): all outputs 0, FSM=IDLE, tag counter=0, counters=0, enable=1, skid buffer empty.
- Skid buffer: 2 entries.
  - avalon_st_rx_ready = registered (entries<2 after this cycle's activity) && enable-gate.
  - pnode_valid = entries!=0.
  - A pop occurs on pnode_valid&&pnode_ready.
  - Latency input->output is 1 cycle when empty and pnode_ready=1.
  - Push and pop in the same cycle keep the count.
  - pnode_data and pnode_valid are held stable while pnode_ready=0.
- FSM, evaluated on each accepted input beat:
  - IDLE, sop=1: write beat with current tag. If eop=1 as well (single-beat packet) stay IDLE and advance tag; else go to PKT, beatcnt=1.
  - IDLE, sop=0: drop beat, drop_count++ (saturating at all-ones), stay IDLE. Dropped beats never enter the skid buffer.
  - PKT, sop=0: write beat with current tag, beatcnt++. On eop advance tag and go to IDLE.
  - PKT, sop=1 (missing eop): advance tag, drop_count++, then treat as a fresh IDLE sop (written with the new tag).
- Tag arithmetic: increments modulo 2^12, 4095 wraps to 0. It advances exactly once per completed or abandoned packet. All beats of a packet carry identical tags.
- tag_valid / tag_out: pulse asserted on the pop of an eop beat; tag_out = that beat's tag, held until the next pulse.
- pkt_count: 32-bit, wrapping; increments on the pop of each eop beat.
- CSR map:
  - 0: pkt_count (read); write clears it.
  - 1: drop_count (read); write clears it.
  - 2: next tag (read). Write loads it but is applied only in IDLE; a write while in PKT is held pending and applied on the transition to IDLE.
  - 3: bit0 enable.
    - enable=0 in IDLE: ready deasserts immediately.
    - enable=0 in PKT: ready stays asserted until the eop beat is accepted.
    - enable=0 does not stall the output side.
- Counter clears coincident with an increment: the clear wins; the result is 0.
- Mid-packet reset: all state is discarded. The downstream header capture resynchronises on the next sop.

Optional Feature:
- Macro PNODE_MAXLEN_EN.
- Defined: adds FSM state DISCARD.
  - In PKT, when beatcnt reaches MAXBEATS-1 and the accepted beat is not eop, the beat is forced to eop=1 on output, the tag advances, and the FSM enters DISCARD. This truncates the packet to MAXBEATS beats.
  - DISCARD swallows beats (ready stays 1) and does not count them individually; drop_count++ once on entry. It returns to IDLE after the input eop.
  - A sop seen in DISCARD is handled as an IDLE sop.
- Undefined: no length limit; beatcnt is not implemented; the MAXBEATS parameter is ignored.

Test Plan:
- Three 4-beat packets, pnode_ready=1: pnode_data[141:130] = 0,1,2 on every beat of the respective packet; tag_valid pulses 3 times with tag_out 0,1,2; CSR0 reads 3.
- CSR2 write 4094, then five single-beat packets: tags 4094,4095,0,1,2 (wrap); sop=eop=1 on each output beat.
- pnode_ready held 0 for 10 cycles during a packet: at most 2 beats buffered, avalon_st_rx_ready=0 from the 3rd cycle; data stable; no beat lost or duplicated after release.
- Stray beat without sop in IDLE, then sop inside a packet: stray beat absent from output; second packet carries tag+1 relative to the abandoned one; CSR1 reads 2.
- Write CSR3=0 mid-packet: remaining beats through eop accepted, then avalon_st_rx_ready=0; CSR3=1 resumes acceptance.
- PNODE_MAXLEN_EN, MAXBEATS=4, 7-beat packet: 4 output beats, the 4th with eop=1; input beats 5-7 swallowed; next packet tag+1; CSR1 reads 1.
